// File: rtl/demux_dispatch.sv
// Sequenced 1-to-2 word dispatcher: alternates an input word stream between two one-entry holding slots.
// Optional DEMUX_DISPATCH_SKIP_EN routes a word to the other slot when the targeted slot is blocked.
module demux_dispatch #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             outA_valid,
    output logic [WIDTH-1:0] outA_data,
    input  logic             outA_ready,
    output logic             outB_valid,
    output logic [WIDTH-1:0] outB_data,
    input  logic             outB_ready,
    output logic             ptr
);

    logic             r_ptr;
    logic             r_fullA;
    logic             r_fullB;
    logic [WIDTH-1:0] r_dataA;
    logic [WIDTH-1:0] r_dataB;

    logic w_freeA;
    logic w_freeB;
    logic w_sel;
    logic w_ready;
    logic w_xfer;
    logic w_loadA;
    logic w_loadB;
    logic w_drainA;
    logic w_drainB;

    // A slot can take a word if it is empty or being drained in this same cycle.
    assign w_freeA = ~r_fullA | outA_ready;
    assign w_freeB = ~r_fullB | outB_ready;

`ifdef DEMUX_DISPATCH_SKIP_EN
    always_comb begin
        w_sel = r_ptr;
        if (r_ptr ? ~w_freeB : ~w_freeA) begin
            w_sel = ~r_ptr;
        end
    end
    assign w_ready = w_freeA | w_freeB;
`else
    assign w_sel   = r_ptr;
    assign w_ready = r_ptr ? w_freeB : w_freeA;
`endif

    assign w_xfer   = in_valid & w_ready;
    assign w_loadA  = w_xfer & ~w_sel;
    assign w_loadB  = w_xfer & w_sel;
    assign w_drainA = r_fullA & outA_ready;
    assign w_drainB = r_fullB & outB_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= 1'b0;
            r_fullA <= 1'b0;
            r_fullB <= 1'b0;
            r_dataA <= '0;
            r_dataB <= '0;
        end else begin
            if (w_loadA) begin
                r_dataA <= in_data;
                r_fullA <= 1'b1;
            end else if (w_drainA) begin
                r_fullA <= 1'b0;
            end

            if (w_loadB) begin
                r_dataB <= in_data;
                r_fullB <= 1'b1;
            end else if (w_drainB) begin
                r_fullB <= 1'b0;
            end

            // Pointer moves past the slot actually used; in skip mode that leaves it on the blocked slot.
            if (w_xfer) begin
                r_ptr <= ~w_sel;
            end
        end
    end

    assign in_ready   = w_ready;
    assign outA_valid = r_fullA;
    assign outA_data  = r_dataA;
    assign outB_valid = r_fullB;
    assign outB_data  = r_dataB;
    assign ptr        = r_ptr;

endmodule

// File: tb/tb_demux_dispatch.sv
// Self-checking bench for demux_dispatch: directed scenarios plus randomized traffic against a queue-based model.
module tb_demux_dispatch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        outA_valid;
    logic [15:0] outA_data;
    logic        outA_ready;
    logic        outB_valid;
    logic [15:0] outB_data;
    logic        outB_ready;
    logic        ptr;

    logic        n_in_valid;
    logic        n_in_data;
    logic        n_in_ready;
    logic        n_outA_valid;
    logic        n_outA_data;
    logic        n_outA_ready;
    logic        n_outB_valid;
    logic        n_outB_data;
    logic        n_outB_ready;
    logic        n_ptr;

    demux_dispatch #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .outA_valid(outA_valid), .outA_data(outA_data), .outA_ready(outA_ready),
        .outB_valid(outB_valid), .outB_data(outB_data), .outB_ready(outB_ready),
        .ptr(ptr)
    );

    demux_dispatch #(.WIDTH(1)) dut_narrow (
        .clk(clk), .rst(rst),
        .in_valid(n_in_valid), .in_data(n_in_data), .in_ready(n_in_ready),
        .outA_valid(n_outA_valid), .outA_data(n_outA_data), .outA_ready(n_outA_ready),
        .outB_valid(n_outB_valid), .outB_data(n_outB_data), .outB_ready(n_outB_ready),
        .ptr(n_ptr)
    );

    int nvec  = 0;
    int nfail = 0;

    // Reference model: each slot is a queue of at most one word; accepted words are logged for order checks.
    logic [15:0] qA[$];
    logic [15:0] qB[$];
    logic [15:0] lastA;
    logic [15:0] lastB;
    int          tgt;
    logic [15:0] sent[$];
    int          nA;
    int          nB;
    bit          stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit slot_free(input int s);
        if (s == 0) return (qA.size() == 0) || (outA_ready === 1'b1);
        return (qB.size() == 0) || (outB_ready === 1'b1);
    endfunction

    task automatic model_reset();
        qA.delete();
        qB.delete();
        lastA = '0;
        lastB = '0;
        tgt   = 0;
        sent.delete();
        nA    = 0;
        nB    = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        int  dest;
        bit  rdy;
        @(negedge clk);
        dest = tgt;
`ifdef DEMUX_DISPATCH_SKIP_EN
        if (!slot_free(tgt) && slot_free(1 - tgt)) dest = 1 - tgt;
        rdy = slot_free(0) || slot_free(1);
`else
        rdy = slot_free(tgt);
`endif
        chk("in_ready",   32'(in_ready),   32'(rdy));
        chk("outA_valid", 32'(outA_valid), 32'(qA.size() != 0));
        chk("outA_data",  32'(outA_data),  32'(lastA));
        chk("outB_valid", 32'(outB_valid), 32'(qB.size() != 0));
        chk("outB_data",  32'(outB_data),  32'(lastB));
        chk("ptr",        32'(ptr),        32'(tgt));
        stall = (in_valid === 1'b1) && !rdy && (rst !== 1'b1);
        @(posedge clk);
        #1;
        if (rst === 1'b1) begin
            model_reset();
        end else begin
            if (qA.size() != 0 && outA_ready === 1'b1) begin
`ifndef DEMUX_DISPATCH_SKIP_EN
                if (2 * nA < sent.size()) chk("orderA", 32'(qA[0]), 32'(sent[2 * nA]));
`endif
                nA++;
                void'(qA.pop_front());
            end
            if (qB.size() != 0 && outB_ready === 1'b1) begin
`ifndef DEMUX_DISPATCH_SKIP_EN
                if (2 * nB + 1 < sent.size()) chk("orderB", 32'(qB[0]), 32'(sent[2 * nB + 1]));
`endif
                nB++;
                void'(qB.pop_front());
            end
            if (in_valid === 1'b1 && rdy) begin
                sent.push_back(in_data);
                if (dest == 0) begin
                    qA.push_back(in_data);
                    lastA = in_data;
                end else begin
                    qB.push_back(in_data);
                    lastB = in_data;
                end
                tgt = 1 - dest;
            end
        end
    endtask

    initial begin
        model_reset();
        stall        = 1'b0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        outA_ready   = 1'b1;
        outB_ready   = 1'b1;
        n_in_valid   = 1'b0;
        n_in_data    = 1'b0;
        n_outA_ready = 1'b1;
        n_outB_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset then idle
        cycle();
        rst = 1'b0;
        chk("rst_ptr",     32'(ptr),        32'd0);
        chk("rst_A_valid", 32'(outA_valid), 32'd0);
        chk("rst_B_valid", 32'(outB_valid), 32'd0);
        chk("rst_A_data",  32'(outA_data),  32'd0);
        chk("rst_B_data",  32'(outB_data),  32'd0);
        chk("rst_ready",   32'(in_ready),   32'd1);
        chk("rst_n_ready", 32'(n_in_ready), 32'd1);

        // Stream 1..4 with both consumers ready
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            chk("stream_ready", 32'(in_ready), 32'd1);
            cycle();
            if (i % 2 == 1) begin
                chk("stream_A_valid", 32'(outA_valid), 32'd1);
                chk("stream_A_data",  32'(outA_data),  32'(i));
            end else begin
                chk("stream_B_valid", 32'(outB_valid), 32'd1);
                chk("stream_B_data",  32'(outB_data),  32'(i));
            end
        end
        in_valid = 1'b0;
        cycle();

        // Slow consumer A: AA held, BB to B, CC stalls then refills A as AA drains
        outA_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 16'h00AA;
        cycle();
        chk("slow_A_data", 32'(outA_data), 32'h00AA);
        in_data = 16'h00BB;
        cycle();
`ifndef DEMUX_DISPATCH_SKIP_EN
        chk("slow_B_data", 32'(outB_data), 32'h00BB);
`endif
        in_data = 16'h00CC;
`ifndef DEMUX_DISPATCH_SKIP_EN
        chk("slow_stall_ready", 32'(in_ready), 32'd0);
`endif
        cycle();
`ifndef DEMUX_DISPATCH_SKIP_EN
        chk("slow_stall_ready2", 32'(in_ready), 32'd0);
        chk("slow_A_held",       32'(outA_data), 32'h00AA);
        cycle();
`else
        chk("skip_B_data", 32'(outB_data), 32'h00CC);
        chk("skip_ptr",    32'(ptr),       32'd0);
        in_valid = 1'b0;
        cycle();
`endif
        outA_ready = 1'b1;
        cycle();
`ifndef DEMUX_DISPATCH_SKIP_EN
        chk("slow_A_refill_valid", 32'(outA_valid), 32'd1);
        chk("slow_A_refill_data",  32'(outA_data),  32'h00CC);
`endif

        // Full slot A drained and refilled in the same cycle
        in_valid   = 1'b0;
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        cycle();
        cycle();
        outA_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = (ptr == 1'b0) ? 16'h1111 : 16'h5555;
        if (ptr == 1'b1) begin
            cycle();
            in_data = 16'h1111;
        end
        cycle();
        chk("refill_A_pre", 32'(outA_data), 32'h1111);
        in_data = 16'h2222;
        cycle();
        outA_ready = 1'b1;
        in_data    = 16'h1234;
        cycle();
        chk("refill_A_valid", 32'(outA_valid), 32'd1);
        chk("refill_A_data",  32'(outA_data),  32'h1234);

        // Reset with both slots full and a word offered
        outA_ready = 1'b0;
        outB_ready = 1'b0;
        in_data    = 16'h7777;
        cycle();
        cycle();
        chk("pre_rst_fullA", 32'(outA_valid), 32'd1);
        chk("pre_rst_fullB", 32'(outB_valid), 32'd1);
        rst        = 1'b1;
        in_valid   = 1'b1;
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        in_data    = 16'h9999;
        cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_A_valid", 32'(outA_valid), 32'd0);
        chk("midrst_B_valid", 32'(outB_valid), 32'd0);
        chk("midrst_ptr",     32'(ptr),        32'd0);
        chk("midrst_A_data",  32'(outA_data),  32'd0);

        // One-bit build: 1,0,1 lands as A:1, B:0, A:1
        n_in_valid = 1'b1;
        n_in_data  = 1'b1;
        cycle();
        chk("w1_A_first",  32'(n_outA_data),  32'd1);
        chk("w1_A_valid",  32'(n_outA_valid), 32'd1);
        n_in_data = 1'b0;
        cycle();
        chk("w1_B_data",   32'(n_outB_data),  32'd0);
        chk("w1_B_valid",  32'(n_outB_valid), 32'd1);
        n_in_data = 1'b1;
        cycle();
        chk("w1_A_second", 32'(n_outA_data),  32'd1);
        chk("w1_ptr",      32'(n_ptr),        32'd1);
        n_in_valid = 1'b0;

        // Randomized traffic; a stalled producer holds its word
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            if (!stall) begin
                in_valid = ($urandom_range(9) < 7);
                in_data  = 16'($urandom);
            end
            outA_ready = ($urandom_range(3) != 0);
            outB_ready = ($urandom_range(3) < ((c / 500) % 4));
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
